// File: rtl/mux_rr_scheduler_pkg.sv
// rtl/mux_rr_scheduler_pkg.sv - shared states and width helper for the round-robin scheduler
`timescale 1ns/1ps

package mux_rr_scheduler_pkg;

    // Scheduler FSM: IDLE arbitrates, GRANT streams beats from the owner.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    // Ceiling log2 with a floor of 1 so a selector always has at least one bit.
    function automatic int clog2_min1(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// rtl/mux_rr_scheduler_if.sv - requester/downstream handshake bundle for the scheduler
`timescale 1ns/1ps

interface mux_rr_scheduler_if #(
    parameter int INPORTCNT   = 2,
    parameter int INPORTWIDTH = 4
) ();
    import mux_rr_scheduler_pkg::*;

    localparam int SEL_W = clog2_min1(INPORTCNT);

    logic [INPORTCNT-1:0]             in_valid;
    logic [INPORTWIDTH*INPORTCNT-1:0] in_data;
    logic [INPORTCNT-1:0]             in_ready;
    logic                             out_valid;
    logic [INPORTWIDTH-1:0]           out_data;
    logic                             out_ready;
    logic [SEL_W-1:0]                 out_sel;
    logic [INPORTCNT-1:0]             grant;

    // The scheduler itself sits on the slave side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        output grant
    );

    // Requesters plus downstream consumer drive the master side.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        input  grant
    );

endinterface

// File: rtl/mux_rr_scheduler_rr_pick.sv
// rtl/mux_rr_scheduler_rr_pick.sv - combinational round-robin picker, first request at or above ptr
`timescale 1ns/1ps

module rr_pick
    import mux_rr_scheduler_pkg::*;
#(
    parameter int N = 2,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             any_o,
    output logic [SEL_W-1:0] pick_o
);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [SEL_W-1:0] offset;
    logic [SEL_W:0]   sum;

    // Rotate requests so ptr lands at bit 0, find the nearest set bit, then rotate the index back.
    always_comb begin
        req_dbl = {req_i, req_i};
        req_rot = req_dbl[ptr_i +: N];
        offset  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = SEL_W'(k);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, offset};
        if (sum >= (SEL_W + 1)'(N)) begin
            sum = sum - (SEL_W + 1)'(N);
        end
        any_o  = |req_i;
        pick_o = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin burst scheduler sharing one registered output lane
`timescale 1ns/1ps

module mux_rr_scheduler
    import mux_rr_scheduler_pkg::*;
#(
    parameter int INPORTCNT   = 2,
    parameter int INPORTWIDTH = 4,
    parameter int BURST_MAX   = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux_rr_scheduler_if.slave bus
);

    localparam int SEL_W = clog2_min1(INPORTCNT);
    localparam int CNT_W = clog2_min1(BURST_MAX);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);
    localparam logic [SEL_W-1:0] LAST_PORT = SEL_W'(INPORTCNT - 1);

    sched_state_e           state_q, state_d;
    logic [SEL_W-1:0]       ptr_q, ptr_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [INPORTCNT-1:0]   grant_q, grant_d;
    logic                   out_valid_q, out_valid_d;
    logic [INPORTWIDTH-1:0] out_data_q, out_data_d;

    logic [INPORTCNT-1:0]   in_ready_c;
    logic                   pick_any;
    logic [SEL_W-1:0]       pick_idx;
    logic                   owner_valid;
    logic                   owner_ready;
    logic                   xfer;

    rr_pick #(
        .N (INPORTCNT)
    ) u_pick (
        .req_i  (bus.in_valid),
        .ptr_i  (ptr_q),
        .any_o  (pick_any),
        .pick_o (pick_idx)
    );

    // The owner may push a beat whenever the output register is empty or draining this cycle.
    assign owner_valid = bus.in_valid[sel_q];
    assign owner_ready = !out_valid_q || bus.out_ready;

    // Arbitration, burst accounting and output-register next state.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        burst_cnt_d = burst_cnt_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready_c  = '0;
        xfer        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    sel_d             = pick_idx;
                    burst_cnt_d       = '0;
                    state_d           = GRANT;
                end
            end
            GRANT: begin
                in_ready_c[sel_q] = owner_ready;
                xfer              = owner_valid && owner_ready;
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // Dropping valid forfeits the turn; a full burst hands over after its last beat.
                if (!owner_valid || (xfer && (burst_cnt_q == LAST_BEAT))) begin
                    grant_d = '0;
                    state_d = IDLE;
                    ptr_d   = (sel_q == LAST_PORT) ? '0 : sel_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new beat replaces the register even while the old one is being accepted.
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[sel_q*INPORTWIDTH +: INPORTWIDTH];
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any beat held in the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            burst_cnt_q <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = sel_q;
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb/tb_mux_rr_scheduler.sv - self-checking bench for mux_rr_scheduler with a behavioural model
`timescale 1ns/1ps

module tb_mux_rr_scheduler;

    localparam int W = 4;
    localparam int B = 4;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_rr_scheduler_if #(.INPORTCNT(2), .INPORTWIDTH(W)) if2 ();
    mux_rr_scheduler_if #(.INPORTCNT(3), .INPORTWIDTH(W)) if3 ();

    mux_rr_scheduler #(.INPORTCNT(2), .INPORTWIDTH(W), .BURST_MAX(B)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    mux_rr_scheduler #(.INPORTCNT(3), .INPORTWIDTH(W), .BURST_MAX(B)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    // Model: who owns the lane (-1 = nobody), beats given, next turn, and the output slot.
    typedef struct {
        int owner;
        int beats;
        int ptr;
        int sel;
        int ov;
        int od;
    } model_t;

    model_t m2, m3;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    bit checking = 0;

    int beat2_d[$];
    int beat2_c[$];
    int sel2_log[$];
    int sel3_log[$];
    int g2_prev = 0;
    int g3_prev = 0;

    function automatic model_t model_reset();
        model_t r;
        r.owner = -1;
        r.beats = 0;
        r.ptr   = 0;
        r.sel   = 0;
        r.ov    = 0;
        r.od    = 0;
        return r;
    endfunction

    function automatic model_t model_next(model_t s, int n, int valid, int data, int ordy);
        model_t r;
        int idx;
        int g;
        int has;
        int take;
        r = s;
        if (s.owner < 0) begin
            for (int k = 0; k < n; k++) begin
                idx = (s.ptr + k) % n;
                if (r.owner < 0 && ((valid >> idx) & 1) == 1) begin
                    r.owner = idx;
                    r.sel   = idx;
                    r.beats = 0;
                end
            end
            if (s.ov != 0 && ordy != 0) r.ov = 0;
        end else begin
            g    = s.owner;
            has  = (valid >> g) & 1;
            take = (has != 0 && (s.ov == 0 || ordy != 0)) ? 1 : 0;
            if (take != 0) begin
                r.od    = (data >> (g * W)) & ((1 << W) - 1);
                r.ov    = 1;
                r.beats = s.beats + 1;
            end else if (s.ov != 0 && ordy != 0) begin
                r.ov = 0;
            end
            if (has == 0 || r.beats == B) begin
                r.owner = -1;
                r.ptr   = (g + 1) % n;
            end
        end
        return r;
    endfunction

    function automatic int exp_grant(model_t s);
        return (s.owner < 0) ? 0 : (1 << s.owner);
    endfunction

    function automatic int exp_ready(model_t s, int ordy);
        return (s.owner >= 0 && (s.ov == 0 || ordy != 0)) ? (1 << s.owner) : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    // Reference model advances on the same edges as the DUTs and clears asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2 <= model_reset();
            m3 <= model_reset();
        end else begin
            m2 <= model_next(m2, 2, int'(if2.in_valid), int'(if2.in_data), int'(if2.out_ready));
            m3 <= model_next(m3, 3, int'(if3.in_valid), int'(if3.in_data), int'(if3.out_ready));
        end
    end

    // Compare both DUTs to the model mid-cycle and log accepted beats and new grants.
    always @(negedge clk) begin
        cyc++;
        if (checking) begin
            check("dut2.out_valid", if2.out_valid, m2.ov);
            check("dut2.out_data",  if2.out_data,  m2.od);
            check("dut2.out_sel",   if2.out_sel,   m2.sel);
            check("dut2.grant",     if2.grant,     exp_grant(m2));
            check("dut2.in_ready",  if2.in_ready,  exp_ready(m2, int'(if2.out_ready)));
            check("dut3.out_valid", if3.out_valid, m3.ov);
            check("dut3.out_data",  if3.out_data,  m3.od);
            check("dut3.out_sel",   if3.out_sel,   m3.sel);
            check("dut3.grant",     if3.grant,     exp_grant(m3));
            check("dut3.in_ready",  if3.in_ready,  exp_ready(m3, int'(if3.out_ready)));
        end
        if (rst_n && if2.out_valid && if2.out_ready) begin
            beat2_d.push_back(int'(if2.out_data));
            beat2_c.push_back(cyc);
        end
        if (int'(if2.grant) != g2_prev && if2.grant != 0) sel2_log.push_back(int'(if2.out_sel));
        if (int'(if3.grant) != g3_prev && if3.grant != 0) sel3_log.push_back(int'(if3.out_sel));
        g2_prev = int'(if2.grant);
        g3_prev = int'(if3.grant);
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        if2.in_valid  = '0;
        if2.in_data   = '0;
        if2.out_ready = 1'b1;
        if3.in_valid  = '0;
        if3.in_data   = '0;
        if3.out_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int sbase;
        int val;
        int takes;
        int held;
        bit took;
        bit found;

        rst_n = 1'b1;
        idle_inputs();
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        checking = 1;
        check("reset_out_valid", if2.out_valid, 0);
        check("reset_grant", if2.grant, 0);

        // Single source: 1..6 from requester 0, four-beat bursts separated by one idle cycle.
        do_reset();
        base = beat2_d.size();
        val  = 1;
        if2.in_valid = 2'b01;
        if2.in_data  = 8'h01;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            took = if2.in_ready[0] && if2.in_valid[0];
            @(posedge clk);
            #2;
            if (took) begin
                val++;
                if (val > 6) if2.in_valid = '0;
                else         if2.in_data[3:0] = 4'(val);
            end
        end
        check("single_count", beat2_d.size() - base, 6);
        if (beat2_d.size() - base >= 6) begin
            for (int i = 0; i < 6; i++) check("single_data", beat2_d[base + i], i + 1);
            check("single_gap_12", beat2_c[base + 1] - beat2_c[base + 0], 1);
            check("single_gap_34", beat2_c[base + 3] - beat2_c[base + 2], 1);
            check("single_bubble", beat2_c[base + 4] - beat2_c[base + 3], 2);
            check("single_gap_56", beat2_c[base + 5] - beat2_c[base + 4], 1);
        end

        // Alternation: both requesters always valid, then an asynchronous reset mid-burst.
        do_reset();
        base  = beat2_d.size();
        sbase = sel2_log.size();
        if2.in_valid = 2'b11;
        if2.in_data  = 8'hBA;
        repeat (17) begin
            @(posedge clk);
            #2;
        end
        check("alt_count_ok", (beat2_d.size() - base >= 12) ? 1 : 0, 1);
        if (beat2_d.size() - base >= 12) begin
            for (int i = 0; i < 12; i++) check("alt_data", beat2_d[base + i], (i >= 4 && i < 8) ? 11 : 10);
            check("alt_gap_ab", beat2_c[base + 4] - beat2_c[base + 3], 2);
            check("alt_gap_ba", beat2_c[base + 8] - beat2_c[base + 7], 2);
        end
        check("alt_sel_count_ok", (sel2_log.size() - sbase >= 3) ? 1 : 0, 1);
        if (sel2_log.size() - sbase >= 3) begin
            check("alt_sel0", sel2_log[sbase + 0], 0);
            check("alt_sel1", sel2_log[sbase + 1], 1);
            check("alt_sel2", sel2_log[sbase + 2], 0);
        end
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (if2.grant == 2'b10 && if2.out_valid) found = 1;
            else begin
                @(posedge clk);
                #2;
            end
        end
        check("rst_precondition", found, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", if2.out_valid, 0);
        check("rst_async_grant", if2.grant, 0);
        check("rst_async_in_ready", if2.in_ready, 0);
        check("rst_async_out_sel", if2.out_sel, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("rst_first_grant", if2.grant, 2'b01);

        // Backpressure: hold out_ready low for three cycles once beat 2 is in the register.
        do_reset();
        base = beat2_d.size();
        val  = 1;
        if2.in_valid  = 2'b01;
        if2.in_data   = 8'h01;
        if2.out_ready = 1'b1;
        held = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            took = if2.in_ready[0] && if2.in_valid[0];
            if (c >= 3 && c <= 5) begin
                check("bp_in_ready", if2.in_ready[0], 0);
                check("bp_frozen", if2.out_data, 2);
                check("bp_valid", if2.out_valid, 1);
            end
            @(posedge clk);
            #2;
            if (took) begin
                val++;
                if2.in_data[3:0] = 4'(val);
            end
            if2.out_ready = !((c + 1) >= 3 && (c + 1) <= 5);
        end
        if2.in_valid = '0;
        check("bp_count_ok", (beat2_d.size() - base >= 6) ? 1 : 0, 1);
        if (beat2_d.size() - base >= 6) begin
            for (int i = 0; i < 6; i++) check("bp_data", beat2_d[base + i], i + 1);
            check("bp_resume", beat2_c[base + 2] - beat2_c[base + 1], 1);
        end

        // Early release: requester 0 drops valid after two beats while requester 1 waits.
        do_reset();
        if2.in_valid = 2'b11;
        if2.in_data  = 8'hBA;
        takes = 0;
        for (int c = 0; c < 10 && takes < 2; c++) begin
            @(negedge clk);
            if (if2.in_ready[0] && if2.in_valid[0]) takes++;
            @(posedge clk);
            #2;
        end
        check("early_takes", takes, 2);
        if2.in_valid[0] = 1'b0;
        @(negedge clk);
        check("early_grant_hold", if2.grant, 2'b01);
        @(negedge clk);
        check("early_grant_idle", if2.grant, 2'b00);
        @(negedge clk);
        check("early_grant_next", if2.grant, 2'b10);
        check("early_sel_next", if2.out_sel, 1);
        idle_inputs();

        // Wrap with three requesters: only 0 and 2 valid, requester 1 never served.
        do_reset();
        sbase = sel3_log.size();
        if3.in_valid = 3'b101;
        if3.in_data  = 12'h301;
        repeat (25) begin
            @(posedge clk);
            #2;
        end
        check("wrap_count_ok", (sel3_log.size() - sbase >= 4) ? 1 : 0, 1);
        if (sel3_log.size() - sbase >= 4) begin
            check("wrap_sel0", sel3_log[sbase + 0], 0);
            check("wrap_sel1", sel3_log[sbase + 1], 2);
            check("wrap_sel2", sel3_log[sbase + 2], 0);
            check("wrap_sel3", sel3_log[sbase + 3], 2);
        end
        idle_inputs();

        // Randomized traffic on both instances with occasional mid-run resets.
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #2;
            rst_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 2; i++) if2.in_valid[i] = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < 3; i++) if3.in_valid[i] = ($urandom_range(0, 7) != 0);
            if2.in_data   = 8'($urandom);
            if3.in_data   = 12'($urandom);
            if2.out_ready = ($urandom_range(0, 3) != 0);
            if3.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
